// File: rtl/bcd_scan_display_pkg.sv
// rtl/bcd_scan_display_pkg.sv - segment constants, glyph table and display-word layout
package bcd_scan_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a} glyphs, indexed by digit value 0-9.
  localparam logic [9:0][6:0] SEG_GLYPH = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  localparam int SEC_LO_LSB = 0;
  localparam int SEC_HI_LSB = 4;
  localparam int SPACER_BIT = 7;
  localparam int MIN_LO_LSB = 8;
  localparam int MIN_HI_LSB = 12;

  typedef enum logic [1:0] {
    DIG_SEC_LO = 2'd0,
    DIG_SEC_HI = 2'd1,
    DIG_MIN_LO = 2'd2,
    DIG_MIN_HI = 2'd3
  } digit_e;

endpackage

// File: rtl/bcd_scan_display_seg7.sv
// rtl/bcd_scan_display_seg7.sv - combinational BCD to active-low 7-segment decoder
module bcd_to_seg7
  import bcd_scan_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) seg = SEG_GLYPH[bcd];
  end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - 4-digit multiplexed 7-segment scan driver with frame snapshot and blink
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter int DIV       = 9,
  parameter int DEAD      = 4,
  parameter int BLINK_DIV = 5,
  parameter int LZB       = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] display,
  input  logic        flash,
  input  logic        colon_blink,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam logic [DIV-1:0] DEAD_V = DIV'(DEAD);

  logic [DIV-1:0]       presc, presc_n;
  digit_e               idx, idx_n;
  logic [15:0]          snap, snap_n;
  logic [BLINK_DIV-1:0] bcnt, bcnt_n;
  logic                 phase, phase_n;

  logic [3:0] digit;
  logic [6:0] glyph;
  logic       dark;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      idx   <= DIG_SEC_LO;
      snap  <= '0;
      bcnt  <= '0;
      phase <= 1'b0;
      an    <= 4'b1111;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      presc <= presc_n;
      idx   <= idx_n;
      snap  <= snap_n;
      bcnt  <= bcnt_n;
      phase <= phase_n;
      an    <= an_d;
      seg   <= seg_d;
      dp    <= dp_d;
    end
  end

  // The snapshot and blink counter advance only on the wrap out of the last slot,
  // so a frame never mixes digits from two display words.
  always_comb begin
    presc_n = presc + DIV'(1);
    idx_n   = idx;
    snap_n  = snap;
    bcnt_n  = bcnt;
    phase_n = phase;
    if (&presc) begin
      idx_n = digit_e'(idx + 2'd1);
      if (idx == DIG_MIN_HI) begin
        snap_n = display;
        bcnt_n = bcnt + BLINK_DIV'(1);
        if (&bcnt) phase_n = ~phase;
      end
    end
  end

  always_comb begin
    digit = 4'd0;
    case (idx)
      DIG_SEC_LO: digit = snap[SEC_LO_LSB +: 4];
      DIG_SEC_HI: digit = {1'b0, snap[SEC_HI_LSB +: 3]};
      DIG_MIN_LO: digit = snap[MIN_LO_LSB +: 4];
      DIG_MIN_HI: digit = snap[MIN_HI_LSB +: 4];
      default:    digit = 4'd0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (digit),
    .seg (glyph)
  );

  always_comb begin
    dark = (presc < DEAD_V) || (flash && !phase) ||
           ((LZB != 0) && (idx == DIG_MIN_HI) && (digit == 4'd0));
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!dark) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = glyph;
      dp_d  = !((idx == DIG_MIN_LO) && (!colon_blink || phase));
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - self-checking bench for bcd_scan_display
module tb_bcd_scan_display;

  localparam int DIV       = 4;
  localparam int DEAD      = 2;
  localparam int BLINK_DIV = 1;
  localparam int SLOT      = 1 << DIV;
  localparam int FRAME     = 4 * SLOT;
  localparam int HMAX      = 2048;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] display = 16'h0000;
  logic        flash = 1'b0;
  logic        colon_blink = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int passes = 0;
  int edge_cnt = 0;

  logic [15:0] disp_h  [HMAX];
  logic        flash_h [HMAX];
  logic        colon_h [HMAX];

  bcd_scan_display #(.DIV(DIV), .DEAD(DEAD), .BLINK_DIV(BLINK_DIV), .LZB(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .display     (display),
    .flash       (flash),
    .colon_blink (colon_blink),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  always #5 clk = ~clk;

  // Inputs seen by the DUT at each rising edge since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cnt = 0;
    else begin
      edge_cnt = edge_cnt + 1;
      if (edge_cnt < HMAX) begin
        disp_h[edge_cnt]  = display;
        flash_h[edge_cnt] = flash;
        colon_h[edge_cnt] = colon_blink;
      end
    end
  end

  function automatic logic [6:0] glyph_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Expected pins after rising edge n: they reflect the scan position reached after n-1 edges.
  task automatic model(input int n, output logic [3:0] e_an, output logic [6:0] e_seg, output logic e_dp);
    int s, p, k, f, v, d, ph;
    logic dark;
    s  = n - 1;
    p  = s % SLOT;
    k  = (s / SLOT) % 4;
    f  = s / FRAME;
    v  = (f == 0) ? 0 : int'(disp_h[f * FRAME]);
    ph = (f / (1 << BLINK_DIV)) % 2;
    case (k)
      0:       d = v % 16;
      1:       d = (v / 16) % 8;
      2:       d = (v / 256) % 16;
      default: d = v / 4096;
    endcase
    dark = (p < DEAD) || (flash_h[n] && ph == 0) || (k == 3 && d == 0);
    if (dark) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an  = 4'hF ^ 4'(1 << k);
      e_seg = glyph_of(d);
      e_dp  = !(k == 2 && (!colon_h[n] || ph == 1));
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got === exp) passes = passes + 1;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, got, exp);
  endtask

  always @(negedge clk) begin
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    if (reset_n && edge_cnt >= 1 && edge_cnt < HMAX) begin
      model(edge_cnt, e_an, e_seg, e_dp);
      check("model_an",  32'(an),  32'(e_an));
      check("model_seg", 32'(seg), 32'(e_seg));
      check("model_dp",  32'(dp),  32'(e_dp));
    end
  end

  task automatic wait_edge(input int n);
    int k;
    k = 0;
    while (edge_cnt < n && k < 4000) begin
      @(posedge clk); #1;
      k = k + 1;
    end
    check("wait_edge", 32'(edge_cnt), 32'(n));
  endtask

  task automatic lit(input int n, input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
    wait_edge(n);
    check("lit_an",  32'(an),  32'(e_an));
    check("lit_seg", 32'(seg), 32'(e_seg));
    check("lit_dp",  32'(dp),  32'(e_dp));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    lit(1,  4'hF, 7'h7F,       1'b1);
    lit(3,  4'hE, 7'b1000000,  1'b1);
    lit(19, 4'hD, 7'b1000000,  1'b1);
    lit(35, 4'hB, 7'b1000000,  1'b0);
    lit(51, 4'hF, 7'h7F,       1'b1);
    wait_edge(100); @(negedge clk); display = 16'h1234;
    lit(131, 4'hE, 7'b0011001, 1'b1);
    lit(147, 4'hD, 7'b0110000, 1'b1);
    lit(163, 4'hB, 7'b0100100, 1'b0);
    lit(179, 4'h7, 7'b1111001, 1'b1);
    wait_edge(210); @(negedge clk); display = 16'h0959;
    lit(243, 4'h7, 7'b1111001, 1'b1);
    lit(256, 4'h7, 7'b1111001, 1'b1);
    lit(259, 4'hE, 7'b0010000, 1'b1);
    lit(275, 4'hD, 7'b0010010, 1'b1);
    lit(307, 4'hF, 7'h7F,      1'b1);
    wait_edge(330); @(negedge clk); display = 16'h00AF;
    lit(387, 4'hE, 7'b0111111, 1'b1);
    lit(403, 4'hD, 7'b0100100, 1'b1);
    lit(419, 4'hB, 7'b1000000, 1'b0);
    wait_edge(420); @(negedge clk); flash = 1'b1; colon_blink = 1'b1;
    lit(451, 4'hE, 7'b0111111, 1'b1);
    lit(483, 4'hB, 7'b1000000, 1'b0);
    lit(515, 4'hF, 7'h7F,      1'b1);
    lit(547, 4'hF, 7'h7F,      1'b1);
    wait_edge(580); @(negedge clk); flash = 1'b0;
    lit(611, 4'hB, 7'b1000000, 1'b1);
    lit(643, 4'hE, 7'b0111111, 1'b1);
    lit(677, 4'hB, 7'b1000000, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check("async_an",  32'(an),  32'(4'hF));
    check("async_seg", 32'(seg), 32'(7'h7F));
    check("async_dp",  32'(dp),  32'(1'b1));
    repeat (2) @(negedge clk);
    colon_blink = 1'b0;
    display = 16'h1234;
    reset_n = 1'b1;
    lit(3,  4'hE, 7'b1000000, 1'b1);
    lit(67, 4'hE, 7'b0011001, 1'b1);
    wait_edge(130);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Multiplexed 4-digit 7-segment driver for the countdown timer's 16-bit BCD display word. It snapshots the word once per scan frame (no tearing) and scans one digit per slot with anti-ghosting dead time. It also blanks a leading zero, drives the minutes/seconds separator dot and flashes the whole display on request (timer `finish`). It sits between the timer's `display`/`finish` outputs and the board's segment/anode pins.

## Interface
- `DIV`, 9 — slot length is 2^DIV clocks; frame = 4 slots.
- `DEAD`, 4 — clocks at slot start with all anodes off; legal 0..2^DIV-1.
- `BLINK_DIV`, 5 — blink phase toggles every 2^BLINK_DIV frames.
- `LZB`, 1 — 1: blank digit 3 when it is 0.
- `clk` in 1 — single clock, rising edge.
- `reset_n` in 1 — one clock; reset is asynchronous and active-low.
- `display` in 16 — {min_hi[3:0], min_lo[3:0], spacer, sec_hi[2:0], sec_lo[3:0]}; the spacer is bit 7 and is ignored.
- `flash` in 1 — 1: display on in blink phase 1, dark in phase 0.
- `colon_blink` in 1 — 1: separator dot follows the blink phase; 0: dot is steady on.
- `seg` out 7 — {g,f,e,d,c,b,a}, active-low.
- `dp` out 1 — decimal point, active-low.
- `an` out 4 — digit anodes, active-low, one-hot-or-none.

## Operation
- State:
  - `presc[DIV-1:0]`
  - `idx[1:0]`
  - `snap[15:0]`
  - `bcnt[BLINK_DIV-1:0]`
  - `phase`
- `presc` increments every clock and wraps. At wrap, `idx` increments (3→0 wraps).
- Frame start is a wrap with `idx`==3. On that same edge:
  - `snap` <= `display`
  - `bcnt` increments
  - when `bcnt` wraps, `phase` toggles.
- Digit select from `snap`:
  - idx0 = sec_lo
  - idx1 = {0, sec_hi}
  - idx2 = min_lo
  - idx3 = min_hi
- Decode, 0-9 standard active-low:
  - 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001
  - 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000
  - values 10-15 → dash 7'b0111111.
- `dp` is low only on idx2, when `colon_blink`=0 or `phase`=1.
- The anode is dark (`an`=4'b1111, `seg`=7'h7F, `dp`=1) when any of these holds:
  - `presc` < `DEAD`
  - `flash`=1 and `phase`=0
  - LZB=1, idx=3 and digit value is 0.
- Otherwise `an` = ~(4'b0001 << idx).
- `flash` and `colon_blink` are sampled live each clock (not snapshotted).

## Timing
- Reset values:
  - outputs: `an`=4'b1111, `seg`=7'h7F, `dp`=1
  - state: `presc`=0, `idx`=0, `snap`=0, `bcnt`=0, `phase`=0.
- Outputs are registered and reflect the state of the previous clock (1-cycle latency).
- After reset release, the first frame shows `snap`=0 (digits "0 0 0" + blanked min_hi with LZB).
- A `display` change reaches the pins no earlier than the next frame start plus 1 clock, and no later than 4·2^DIV+1 clocks.
- Dead time covers `presc` 0..DEAD-1 of every slot, including slot 0 after reset.
- Reset asserted mid-frame: all state and outputs clear immediately and asynchronously; scanning restarts at idx0 on release.
- `flash` toggling mid-slot takes effect the next clock.

## Structure
- Shared package (with the timer): the segment constants `SEG_BLANK` and `SEG_DASH`, the 0-9 glyph table, and the display-word field offsets.
- One sub-module `bcd_to_seg7`: combinational 4-bit → 7-bit active-low decoder.
- The scan FSM, snapshot and blink logic stay in the top.

## Test plan
All scenarios use DIV=4, DEAD=2, BLINK_DIV=1 (slot 16, frame 64 clocks).
- Reset, `display`=16'h0000, LZB=1 → `an` cycles 1110/1101/1011 with 1111 in each slot's first 2 output clocks; slot 3 stays 1111.
- `display`=16'h1234 (12:34) held → idx0 `seg`=0011001 ("4"), idx1 0110000, idx2 0100100 with `dp`=0, idx3 1111001.
- Change `display` from 16'h1234 to 16'h0959 at slot 1 → the old digits complete the frame; new digits appear from the next frame start +1 clock; min_hi blank.
- `display`=16'h00AF-style invalid nibbles (sec_lo=F) → idx0 shows dash 0111111.
- `flash`=1 → the display is dark for 2 frames and lit for 2 frames, alternating. `colon_blink`=1 → `dp` on idx2 follows the same phase.
- Assert `reset_n`=0 mid-slot 2 → `an`=1111 and `seg`=7F within the same clock (async). After release, the first slot is idx0.
